// File: rtl/seq_multiplier.sv
// Sequential shift-add multiplier with start/done handshake. Sgn selects
// unsigned add-and-shift or radix-2 Booth recoding for two's-complement operands.
module seq_multiplier #(
  parameter int WIDTH = 8
) (
  input  logic                 Clk,
  input  logic                 Rst_n,
  input  logic                 St,
  input  logic                 Sgn,
  input  logic [WIDTH-1:0]     Mcand,
  input  logic [WIDTH-1:0]     Mplier,
  output logic [2*WIDTH-1:0]   Product,
  output logic                 Idle,
  output logic                 Done,
  output logic                 Load,
  output logic                 Ad,
  output logic                 Sh
);

  localparam int KW = $clog2(WIDTH);
  localparam logic [KW-1:0] K_LAST = KW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CHK  = 2'd1,
    S_SHF  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic signed [WIDTH:0]  a_q, a_d;
  logic [WIDTH-1:0]       q_q, q_d;
  logic [WIDTH-1:0]       b_q, b_d;
  logic                   qm1_q, qm1_d;
  logic                   mode_q, mode_d;
  logic [KW-1:0]          k_q, k_d;
  logic [2*WIDTH-1:0]     prod_q, prod_d;

  logic                   m_bit;
  logic                   sub_op;
  logic                   last_bit;
  logic signed [WIDTH:0]  b_ext;
  logic signed [WIDTH:0]  a_sh;
  logic [WIDTH-1:0]       q_sh;

  // Widen the multiplicand to the accumulator width for the active mode.
  function automatic logic signed [WIDTH:0] ext_b(input logic [WIDTH-1:0] b,
                                                  input logic signed_mode);
    return signed_mode ? $signed({b[WIDTH-1], b}) : $signed({1'b0, b});
  endfunction

  assign m_bit    = mode_q ? (q_q[0] ^ qm1_q) : q_q[0];
  assign sub_op   = mode_q & q_q[0] & ~qm1_q;
  assign last_bit = (k_q == K_LAST);
  assign b_ext    = ext_b(b_q, mode_q);
  // Unsigned shifts the carry bit down; signed replicates the sign.
  assign a_sh     = $signed({mode_q & a_q[WIDTH], a_q[WIDTH:1]});
  assign q_sh     = {a_q[0], q_q[WIDTH-1:1]};

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (St) state_d = S_CHK;
      S_CHK: begin
        if (m_bit)         state_d = S_SHF;
        else if (last_bit) state_d = S_DONE;
        else               state_d = S_CHK;
      end
      S_SHF:  state_d = last_bit ? S_DONE : S_CHK;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Load is qualified by Rst_n so a start held during reset is not reported.
  always_comb begin
    Idle = (state_q == S_IDLE);
    Done = (state_q == S_DONE);
    Load = (state_q == S_IDLE) & St & Rst_n;
    Ad   = (state_q == S_CHK) & m_bit;
    Sh   = ((state_q == S_CHK) & ~m_bit) | (state_q == S_SHF);
  end

  always_comb begin
    a_d    = a_q;
    q_d    = q_q;
    qm1_d  = qm1_q;
    b_d    = b_q;
    mode_d = mode_q;
    k_d    = k_q;
    prod_d = prod_q;
    if (Load) begin
      a_d    = '0;
      q_d    = Mplier;
      qm1_d  = 1'b0;
      b_d    = Mcand;
      mode_d = Sgn;
      k_d    = '0;
    end
    if (Ad) begin
      a_d = sub_op ? (a_q - b_ext) : (a_q + b_ext);
    end
    if (Sh) begin
      a_d   = a_sh;
      q_d   = q_sh;
      qm1_d = q_q[0];
      k_d   = k_q + KW'(1);
      if (last_bit) prod_d = {a_sh[WIDTH-1:0], q_sh};
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      a_q    <= '0;
      q_q    <= '0;
      qm1_q  <= 1'b0;
      b_q    <= '0;
      mode_q <= 1'b0;
      k_q    <= '0;
      prod_q <= '0;
    end else begin
      a_q    <= a_d;
      q_q    <= q_d;
      qm1_q  <= qm1_d;
      b_q    <= b_d;
      mode_q <= mode_d;
      k_q    <= k_d;
      prod_q <= prod_d;
    end
  end

  assign Product = prod_q;

endmodule
